// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset/lock sequencer.
// Optional glitch filter on lock loss in RUN: `define PLL_LOCK_GLITCH_FILTER_EN.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_state_e;

  // Consecutive low cycles of the synchronised lock that count as lock loss in RUN (filter on).
  localparam int unsigned GlitchFiltLen = 4;

  // Width of a counter able to hold (largest of the three cycle counts) - 1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? unsigned'($clog2(m)) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RstVal;
      sync_q <= RstVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_seq.sv
// PLL reset and lock sequencer on the reference clock; releases sys_reset_n after a stable lock.
// Optional: `define PLL_LOCK_GLITCH_FILTER_EN to ignore short lock drops while in RUN.
module pll_lock_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 16,
  parameter int unsigned LOCK_STABLE_CYC  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYC = 500000,
  parameter int unsigned MAX_RETRIES      = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  localparam int unsigned CntW = cnt_width(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC);
  localparam logic [CntW-1:0] RstLast = CntW'(RST_PULSE_CYC - 1);
  localparam logic [CntW-1:0] StbLast = CntW'(LOCK_STABLE_CYC - 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [3:0]      MaxRetry = 4'(MAX_RETRIES);

  pll_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic            pll_rst_q, pll_rst_d;
  logic            sys_reset_n_q, sys_reset_n_d;
  logic            ready_q, ready_d;
  logic            fail_q, fail_d;
  logic            lock_lost_q, lock_lost_d;
  logic            lk;
  logic            lock_loss;

  sync_2ff #(
    .RstVal(1'b0)
  ) u_lock_sync (
    .clk_i (refclk),
    .rst_ni(rst_n),
    .d_i   (pll_locked),
    .q_o   (lk)
  );

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam int unsigned LowCntW = unsigned'($clog2(GlitchFiltLen));

  logic [LowCntW-1:0] low_cnt_q, low_cnt_d;

  assign lock_loss = (state_q == RUN) && !lk && (low_cnt_q == LowCntW'(GlitchFiltLen - 1));
  assign low_cnt_d = ((state_q == RUN) && !lk && !lock_loss) ? low_cnt_q + 1'b1 : '0;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt_q <= '0;
    end else begin
      low_cnt_q <= low_cnt_d;
    end
  end
`else
  assign lock_loss = (state_q == RUN) && !lk;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    if (restart) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          if (cnt_q == RstLast) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // A lock seen on the timeout cycle still wins over the retry.
          if (lk) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TmoLast) begin
            cnt_d = '0;
            if (retry_q == MaxRetry) begin
              state_d = FAIL;
            end else begin
              state_d = RESET_PLL;
              retry_d = retry_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STABLE: begin
          // Any drop restarts the timeout window, even on the completing cycle.
          if (!lk) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == StbLast) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (lock_loss) begin
            state_d     = RESET_PLL;
            cnt_d       = '0;
            retry_d     = '0;
            lock_lost_d = 1'b1;
          end
        end
        FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they flip on the same edge as the state.
  always_comb begin
    pll_rst_d     = (state_d == RESET_PLL) || (state_d == FAIL);
    sys_reset_n_d = (state_d == RUN);
    ready_d       = (state_d == RUN);
    fail_d        = (state_d == FAIL);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RESET_PLL;
      cnt_q         <= '0;
      retry_q       <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      pll_rst_q     <= pll_rst_d;
      sys_reset_n_q <= sys_reset_n_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset_n = sys_reset_n_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Scoreboard bench for pll_lock_seq: stimulus predicts output-change events, a monitor checks them.
module tb_pll_lock_seq;

  localparam int RST  = 4;
  localparam int STB  = 8;
  localparam int TMO  = 32;
  localparam int MAXR = 2;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam bit FILT    = 1'b1;
  localparam int LossLag = 6;
`else
  localparam bit FILT    = 1'b0;
  localparam int LossLag = 3;
`endif

  typedef struct packed {
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [3:0] retry;
  } out_t;

  localparam out_t RstVec = 9'b1_0000_0000;

  logic       refclk = 1'b0;
  logic       rst_n, pll_locked, restart;
  logic       pll_rst, sys_reset_n, ready, fail, lock_lost;
  logic [3:0] retry_count;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  out_t m;
  int   q_edge[$];
  out_t q_val[$];

  pll_lock_seq #(
    .RST_PULSE_CYC   (RST),
    .LOCK_STABLE_CYC (STB),
    .LOCK_TIMEOUT_CYC(TMO),
    .MAX_RETRIES     (MAXR)
  ) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_reset_n(sys_reset_n),
    .ready      (ready),
    .fail       (fail),
    .lock_lost  (lock_lost),
    .retry_count(retry_count)
  );

  always #5 refclk = ~refclk;

  initial begin
    forever begin
      @(posedge refclk);
      cyc++;
    end
  end

  function automatic out_t cur_out();
    return {pll_rst, sys_reset_n, ready, fail, lock_lost, retry_count};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push(input int e);
    q_edge.push_back(e);
    q_val.push_back(m);
  endtask

  task automatic at_neg(input int k);
    if (k < cyc) begin
      n_checks++;
      $display("FAIL schedule: at cycle %0d, wanted cycle %0d", cyc, k);
    end
    while (cyc < k) @(negedge refclk);
  endtask

  // RESET_PLL entered at edge e; pll_rst falls RST edges later.
  task automatic enter_reset(input int e, output int w);
    m.pll_rst     = 1'b1;
    m.sys_reset_n = 1'b0;
    m.ready       = 1'b0;
    m.fail        = 1'b0;
    m.lock_lost   = 1'b0;
    m.retry       = 4'd0;
    push(e);
    w = e + RST;
    m.pll_rst = 1'b0;
    push(w);
  endtask

  // WAIT_LOCK entered at edge w; locked set high (and held) at negedge s.
  // The synchronised level is acted on 3 edges after it is driven, never before w+1.
  task automatic expect_lock(input int w, input int s, output int run_e);
    int st;
    st = (s + 3 > w + 1) ? s + 3 : w + 1;
    run_e = st + STB;
    m.pll_rst     = 1'b0;
    m.sys_reset_n = 1'b1;
    m.ready       = 1'b1;
    push(run_e);
  endtask

  // Monitor: every change of the output vector must match the next predicted event.
  initial begin
    out_t prev, now, v;
    int   e;
    prev = RstVec;
    forever begin
      @(negedge refclk);
      now = cur_out();
      if (now !== prev) begin
        if (q_edge.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_change: got 0x%0h at cycle %0d, none expected", now, cyc);
        end else begin
          e = q_edge.pop_front();
          v = q_val.pop_front();
          check("event_cycle", 32'(cyc), 32'(e));
          check("event_value", 32'(now), 32'(v));
        end
        prev = now;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int r, w, s, q, d, n, g, k, off, run_e, te, le;
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    m          = RstVec;
    #1 rst_n = 1'b0;
    #1 check("reset_state", 32'(cur_out()), 32'(RstVec));
    repeat (3) @(negedge refclk);

    // Nominal first lock after reset release.
    rst_n = 1'b1;
    r = cyc;
    m = RstVec;
    m.pll_rst = 1'b0;
    w = r + RST;
    push(w);
    at_neg(w + int'($urandom_range(1, 10)));
    pll_locked = 1'b1;
    expect_lock(w, cyc, run_e);
    at_neg(run_e + 2);

    // Lock never arrives: all retries used, then FAIL.
    restart    = 1'b1;
    pll_locked = 1'b0;
    q = cyc;
    enter_reset(q + 1, w);
    @(negedge refclk);
    restart = 1'b0;
    te = w;
    for (int a = 0; a <= MAXR; a++) begin
      te = w + TMO;
      m.pll_rst = 1'b1;
      if (a == MAXR) begin
        m.fail = 1'b1;
        push(te);
      end else begin
        m.retry = 4'(a + 1);
        push(te);
        w = te + RST;
        m.pll_rst = 1'b0;
        push(w);
      end
    end
    at_neg(te + int'($urandom_range(2, 6)));

    // Restart out of FAIL, time out k times, then lock (sometimes on the timeout edge itself).
    restart = 1'b1;
    g = cyc;
    enter_reset(g + 1, w);
    @(negedge refclk);
    restart = 1'b0;
    k = int'($urandom_range(0, MAXR));
    for (int i = 0; i < k; i++) begin
      m.pll_rst = 1'b1;
      m.retry   = 4'(i + 1);
      push(w + TMO);
      w = w + TMO + RST;
      m.pll_rst = 1'b0;
      push(w);
    end
    off = ($urandom_range(0, 2) == 0) ? TMO - 3 : int'($urandom_range(0, 10));
    at_neg(w + off);
    pll_locked = 1'b1;
    expect_lock(w, cyc, run_e);
    at_neg(run_e + 2);

    // Lock loss in RUN; short drops are ignored when the filter is built in.
    for (int i = 0; i < 2; i++) begin
      if (FILT) begin
        d = cyc;
        pll_locked = 1'b0;
        at_neg(d + int'($urandom_range(1, 3)));
        pll_locked = 1'b1;
        at_neg(cyc + 8);
      end
      d = cyc;
      pll_locked = 1'b0;
      n = FILT ? int'($urandom_range(4, 6)) : int'($urandom_range(1, 3));
      le = d + LossLag;
      m.pll_rst     = 1'b1;
      m.sys_reset_n = 1'b0;
      m.ready       = 1'b0;
      m.lock_lost   = 1'b1;
      m.retry       = 4'd0;
      push(le);
      m.lock_lost = 1'b0;
      push(le + 1);
      w = le + RST;
      m.pll_rst = 1'b0;
      push(w);
      at_neg(d + n);
      pll_locked = 1'b1;
      expect_lock(w, cyc, run_e);
      at_neg(run_e + 2);
    end

    // Unstable lock (5 high, 1 low, high), then restart on the stable-completion edge.
    restart    = 1'b1;
    pll_locked = 1'b0;
    q = cyc;
    enter_reset(q + 1, w);
    @(negedge refclk);
    restart = 1'b0;
    s = w + int'($urandom_range(0, 5));
    at_neg(s);
    pll_locked = 1'b1;
    at_neg(s + 5);
    pll_locked = 1'b0;
    at_neg(s + 6);
    pll_locked = 1'b1;
    at_neg(s + 9 + STB - 1);
    restart = 1'b1;
    enter_reset(s + 9 + STB, w);
    @(negedge refclk);
    restart = 1'b0;
    expect_lock(w, s + 6, run_e);
    at_neg(run_e + 2);

    // Asynchronous reset in the middle of STABLE.
    restart = 1'b1;
    q = cyc;
    enter_reset(q + 1, w);
    @(negedge refclk);
    restart = 1'b0;
    at_neg(w + 3);
    m = RstVec;
    push(cyc + 1);
    #1 rst_n = 1'b0;
    #1 check("async_reset", 32'(cur_out()), 32'(RstVec));
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
    r = cyc;
    w = r + RST;
    m.pll_rst = 1'b0;
    push(w);
    expect_lock(w, r, run_e);
    at_neg(run_e + 3);

    check("pending_events", 32'(q_edge.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pll_lock_seq.md
# pll_lock_seq

Reset and lock sequencer for the system PLL. Runs on the PLL reference clock, since that clock is valid before lock. Drives the PLL `rst` input, waits for a stable `locked`, then releases the downstream system reset. It retries with a bounded count on lock timeout and restarts the sequence on lock loss. Sits between the top-level reset source and the `altera_pll` wrapper; every core-clock reset domain derives from `sys_reset_n`.

## Interface
Parameters:
- `RST_PULSE_CYC`, 16: refclk cycles `pll_rst` is held high per attempt (≥2).
- `LOCK_STABLE_CYC`, 1024: consecutive synchronised-locked cycles required before release (≥1).
- `LOCK_TIMEOUT_CYC`, 500000: cycles allowed in WAIT_LOCK before retry; 10 ms at 50 MHz.
- `MAX_RETRIES`, 7: retries after the first attempt before FAIL (≤15).

Ports:
- `refclk` in 1: PLL reference clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL `locked`; asynchronous, synchronised internally.
- `restart` in 1: single-cycle request to re-run the full sequence.
- `pll_rst` out 1: to PLL `rst`, active high.
- `sys_reset_n` out 1: downstream reset, active low.
- `ready` out 1: high only in RUN.
- `fail` out 1: high only in FAIL.
- `lock_lost` out 1: one-cycle pulse on lock loss detected in RUN.
- `retry_count` out 4: retries used in the current sequence.

## Operation
- `pll_locked` passes through a 2-flop synchroniser. `lk` denotes its output. All logic uses `lk`.
- Reset state: RESET_PLL with counter=0. Outputs: `pll_rst`=1, `sys_reset_n`=0, `ready`=0, `fail`=0, `lock_lost`=0, `retry_count`=0.
- RESET_PLL: `pll_rst`=1 for RST_PULSE_CYC cycles. Then counter clears and the FSM moves to WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0 and the counter increments.
  - `lk`=1: go to STABLE, counter cleared.
  - Counter reaches LOCK_TIMEOUT_CYC−1 with `lk`=0: if `retry_count`==MAX_RETRIES, go to FAIL. Otherwise increment `retry_count` and go to RESET_PLL.
- STABLE: counter increments while `lk`=1.
  - `lk`=0: back to WAIT_LOCK with counter cleared; the timeout window restarts.
  - Counter reaches LOCK_STABLE_CYC−1: go to RUN.
- RUN: `sys_reset_n`=1, `ready`=1. A lock-loss condition does the following:
  - one-cycle `lock_lost` pulse;
  - `sys_reset_n`=0 and `ready`=0 on the same registered edge;
  - `retry_count` cleared;
  - go to RESET_PLL.
- FAIL: `pll_rst`=1, `sys_reset_n`=0, `fail`=1. Held until `restart` or `rst_n`.
- `restart` (any state): clears `retry_count`, counter and `fail`, and goes to RESET_PLL. It has priority over all other transitions in the same cycle.
- Simultaneous events, same cycle:
  - `lk` drop and stable-count completion: the drop wins (WAIT_LOCK).
  - Timeout and `lk` rise: the rise wins (STABLE).
- The counter is sized `$clog2` of the largest of the three cycle parameters. It never wraps; every state clears it on exit.

## Timing
- All outputs are registered. No combinational input-to-output path exists.
- `pll_locked` to `lk`: 2 cycles.
- First release after `rst_n` deasserts, assuming the PLL locks L cycles after `pll_rst` falls: `sys_reset_n` rises RST_PULSE_CYC + L + 2 + LOCK_STABLE_CYC cycles (±1) after the deassertion.
- In RUN, `sys_reset_n` falls 3 cycles after `pll_locked` falls (2 sync + 1 register) when the filter is compiled out.
- `rst_n` assertion mid-sequence returns every output to its reset value asynchronously.

## Configuration
- Macro `PLL_LOCK_GLITCH_FILTER_EN`, defined: in RUN, lock loss requires `lk`=0 for 4 consecutive cycles. Shorter lows are ignored, and `sys_reset_n` falls 6 cycles after a sustained drop. WAIT_LOCK and STABLE are unaffected.
- Macro undefined: a single `lk`=0 cycle in RUN is lock loss.

## Structure
- Package `pll_seq_pkg` holds:
  - the state enum: RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL;
  - the glitch-filter length constant (4);
  - the counter-width function.
- One sub-module, `sync_2ff`, a reusable 2-flop synchroniser, used for `pll_locked`.

## Test plan
Bench parameters: RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRIES=2.
- Nominal: `locked` rises 5 cycles after `pll_rst` falls and stays high → `pll_rst` high exactly 4 cycles; `sys_reset_n`/`ready` rise ~15 cycles after `pll_rst` falls; `retry_count`=0.
- Timeouts: `locked` held low → 3 RESET_PLL pulses, `retry_count` 0→1→2, then `fail`=1 with `pll_rst`=1. A `restart` pulse → `fail`=0, `retry_count`=0, new 4-cycle pulse.
- Unstable lock: `locked` high 5 cycles, low 1, then high → STABLE restarts and no release before 8 consecutive `lk` cycles.
- Lock loss in RUN: `locked` drops for 1 cycle → filter out: `lock_lost` pulse and `sys_reset_n`=0 3 cycles later. Filter in: no effect. A 4-cycle drop with filter in → release drops 6 cycles after the fall.
- Priority: `restart` in the same cycle as stable completion → RESET_PLL, `ready` stays 0.
- Async reset: `rst_n` low mid-STABLE → all outputs at reset values immediately, before the next `refclk` edge.
